d_flop_debounce: RTL and testbench



---
 rtl/d_flop_debounce_if.sv | 24 ++
 rtl/d_flop_debounce.sv | 120 ++++++++++++
 tb/tb_d_flop_debounce.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/d_flop_debounce_if.sv
// Bus for the d_flop debounce stage: raw bit and controls in, debounced level,
// edge pulses and the rising-edge counter out.
interface d_flop_debounce_if #(
   parameter int CNT_W = 8
);
   logic             din;
   logic             en;
   logic             clr;
   logic             dout;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] edge_cnt;
   logic             cnt_ovf;

   modport master (
      output din, en, clr,
      input  dout, rise, fall, edge_cnt, cnt_ovf
   );

   modport slave (
      input  din, en, clr,
      output dout, rise, fall, edge_cnt, cnt_ovf
   );
endinterface

// File: rtl/d_flop_debounce.sv
// Debounces the d_flop q output: a new level is accepted only after STABLE_CYCLES
// consecutive samples, with registered rise/fall pulses and a saturating rise counter.
module d_flop_debounce #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic               clk,
   input  logic               rstn,
   d_flop_debounce_if.slave   bus
);

   localparam int RUN_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      ST_LO   = 2'd0,
      PEND_HI = 2'd1,
      ST_HI   = 2'd2,
      PEND_LO = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [RUN_W-1:0] run, run_nxt;
   logic             din_r;
   logic             rise_q, fall_q;
   logic             rise_nxt, fall_nxt;
   logic [CNT_W-1:0] edge_cnt;
   logic             cnt_ovf;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         din_r  <= 1'b0;
         state  <= ST_LO;
         run    <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         din_r  <= bus.din;
         state  <= state_nxt;
         run    <= run_nxt;
         rise_q <= rise_nxt;
         fall_q <= fall_nxt;
      end
   end

   // The entry into a pending state already counts as the first stable sample.
   always_comb begin
      state_nxt = state;
      run_nxt   = run;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
         ST_LO: begin
            if (din_r) begin
               state_nxt = PEND_HI;
               run_nxt   = RUN_W'(1);
            end
         end
         PEND_HI: begin
            if (!din_r) begin
               state_nxt = ST_LO;
               run_nxt   = '0;
            end else if (run == RUN_LAST) begin
               state_nxt = ST_HI;
               run_nxt   = '0;
               rise_nxt  = 1'b1;
            end else begin
               run_nxt   = run + RUN_W'(1);
            end
         end
         ST_HI: begin
            if (!din_r) begin
               state_nxt = PEND_LO;
               run_nxt   = RUN_W'(1);
            end
         end
         PEND_LO: begin
            if (din_r) begin
               state_nxt = ST_HI;
               run_nxt   = '0;
            end else if (run == RUN_LAST) begin
               state_nxt = ST_LO;
               run_nxt   = '0;
               fall_nxt  = 1'b1;
            end else begin
               run_nxt   = run + RUN_W'(1);
            end
         end
         default: begin
            state_nxt = ST_LO;
            run_nxt   = '0;
         end
      endcase
   end

   // Clear wins over a rise accepted on the same edge; that rise is simply not counted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         edge_cnt <= '0;
         cnt_ovf  <= 1'b0;
      end else if (bus.clr) begin
         edge_cnt <= '0;
         cnt_ovf  <= 1'b0;
      end else if (bus.en && rise_nxt) begin
         if (edge_cnt != CNT_MAX) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
         end else begin
            cnt_ovf  <= 1'b1;
         end
      end
   end

   assign bus.dout     = (state == ST_HI) || (state == PEND_LO);
   assign bus.rise     = rise_q;
   assign bus.fall     = fall_q;
   assign bus.edge_cnt = edge_cnt;
   assign bus.cnt_ovf  = cnt_ovf;

endmodule

// File: tb/tb_d_flop_debounce.sv
// Directed bench for d_flop_debounce with STABLE_CYCLES=4 and a 3-bit counter so
// saturation is reachable; every expected value below is hand-derived.
module tb_d_flop_debounce;

   logic clk;
   logic rstn;
   int   checks;
   int   failures;
   int   seenRise;
   int   seenFall;
   int   seenDout;

   d_flop_debounce_if #(.CNT_W(3)) bus ();

   d_flop_debounce #(
      .STABLE_CYCLES (4),
      .CNT_W         (3)
   ) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic d, input logic e, input logic c);
      bus.din = d;
      bus.en  = e;
      bus.clr = c;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Holds din high so the accepting edge lands on the 5th tick; clr can be raised on that edge.
   task automatic doRise(input logic e, input logic clrOnAccept);
      applyStimulus(1'b1, e, 1'b0);
      repeat (4) tick;
      applyStimulus(1'b1, e, clrOnAccept);
      tick;
      applyStimulus(1'b1, e, 1'b0);
   endtask

   task automatic doFall(input logic e);
      applyStimulus(1'b0, e, 1'b0);
      repeat (5) tick;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rstn     = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0);
      #12;
      checkOutput("reset_dout", bus.dout, 0);
      checkOutput("reset_rise", bus.rise, 0);
      checkOutput("reset_fall", bus.fall, 0);
      checkOutput("reset_cnt", bus.edge_cnt, 0);
      checkOutput("reset_ovf", bus.cnt_ovf, 0);
      rstn = 1'b1;
      repeat (3) tick;

      // Clean rise
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (4) tick;
      checkOutput("clean_pre_dout", bus.dout, 0);
      checkOutput("clean_pre_rise", bus.rise, 0);
      tick;
      checkOutput("clean_dout", bus.dout, 1);
      checkOutput("clean_rise", bus.rise, 1);
      checkOutput("clean_cnt", bus.edge_cnt, 1);
      tick;
      checkOutput("clean_rise_end", bus.rise, 0);
      checkOutput("clean_dout_hold", bus.dout, 1);

      // Single low sample inside a stable high
      seenFall = 0;
      seenDout = 1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus((i == 1) ? 1'b0 : 1'b1, 1'b1, 1'b0);
         tick;
         seenFall += int'(bus.fall);
         if (!bus.dout) seenDout = 0;
      end
      checkOutput("hi_glitch_fall", seenFall, 0);
      checkOutput("hi_glitch_dout", seenDout, 1);

      // Clean fall
      applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (4) tick;
      checkOutput("fall_pre_dout", bus.dout, 1);
      tick;
      checkOutput("fall_dout", bus.dout, 0);
      checkOutput("fall_pulse", bus.fall, 1);
      checkOutput("fall_no_rise", bus.rise, 0);
      tick;
      checkOutput("fall_pulse_end", bus.fall, 0);

      // Three-sample high pulse is rejected
      seenRise = 0;
      seenDout = 0;
      for (int i = 0; i < 9; i++) begin
         applyStimulus((i < 3) ? 1'b1 : 1'b0, 1'b1, 1'b0);
         tick;
         seenRise += int'(bus.rise);
         if (bus.dout) seenDout = 1;
      end
      checkOutput("lo_glitch_rise", seenRise, 0);
      checkOutput("lo_glitch_dout", seenDout, 0);
      checkOutput("lo_glitch_cnt", bus.edge_cnt, 1);

      // Saturation with a 3-bit counter
      applyStimulus(1'b0, 1'b1, 1'b1);
      tick;
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("sat_clr_cnt", bus.edge_cnt, 0);
      for (int n = 1; n <= 9; n++) begin
         doRise(1'b1, 1'b0);
         if (n == 7) begin
            checkOutput("sat_cnt7", bus.edge_cnt, 7);
            checkOutput("sat_ovf7", bus.cnt_ovf, 0);
         end else if (n == 8) begin
            checkOutput("sat_cnt8", bus.edge_cnt, 7);
            checkOutput("sat_ovf8", bus.cnt_ovf, 1);
         end else if (n == 9) begin
            checkOutput("sat_cnt9", bus.edge_cnt, 7);
            checkOutput("sat_ovf9", bus.cnt_ovf, 1);
         end
         doFall(1'b1);
      end
      applyStimulus(1'b0, 1'b1, 1'b1);
      tick;
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("sat_after_clr_cnt", bus.edge_cnt, 0);
      checkOutput("sat_after_clr_ovf", bus.cnt_ovf, 0);

      // Clear on the accepting edge
      doRise(1'b1, 1'b1);
      checkOutput("coll_rise", bus.rise, 1);
      checkOutput("coll_cnt", bus.edge_cnt, 0);
      doFall(1'b1);
      doRise(1'b1, 1'b0);
      checkOutput("coll_next_cnt", bus.edge_cnt, 1);
      doFall(1'b1);

      // Counting disabled: pulses continue, counter frozen
      for (int n = 0; n < 2; n++) begin
         doRise(1'b0, 1'b0);
         checkOutput("en0_rise", bus.rise, 1);
         checkOutput("en0_cnt", bus.edge_cnt, 1);
         doFall(1'b0);
         checkOutput("en0_fall", bus.fall, 1);
      end

      // Reset in the middle of a pending rise
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick;
      tick;
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("rst_mid_dout", bus.dout, 0);
      checkOutput("rst_mid_rise", bus.rise, 0);
      checkOutput("rst_mid_fall", bus.fall, 0);
      checkOutput("rst_mid_cnt", bus.edge_cnt, 0);
      checkOutput("rst_mid_ovf", bus.cnt_ovf, 0);
      #3;
      rstn = 1'b1;
      repeat (4) tick;
      checkOutput("rst_rel_pre_dout", bus.dout, 0);
      tick;
      checkOutput("rst_rel_dout", bus.dout, 1);
      checkOutput("rst_rel_rise", bus.rise, 1);
      checkOutput("rst_rel_cnt", bus.edge_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
